// File: rtl/mode4_accum_ctrl.sv
// Sequencer that folds a vector of fp16 exponents into one running sum. The adder tree is external.
// Latency: out_valid rises one cycle after the last beat; start to out_valid takes ceil(vec_len/4)+1 cycles at minimum.
// Backpressure: in_ready is high only in ACCUM and drops when abort is high. DONE holds the sum until out_ready.
module mode4_accum_ctrl #(
   parameter int DATAWIDTH = 16,
   parameter int LEN_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [LEN_WIDTH-1:0]   vec_len,
   input  logic                   abort,
   input  logic                   in_valid,
   input  logic [4*DATAWIDTH-1:0] in_data,
   output logic                   in_ready,
   output logic [DATAWIDTH-1:0]   tree_inp0,
   output logic [DATAWIDTH-1:0]   tree_inp1,
   output logic [DATAWIDTH-1:0]   tree_inp2,
   output logic [DATAWIDTH-1:0]   tree_inp3,
   output logic [DATAWIDTH-1:0]   tree_ex_inp,
   input  logic [DATAWIDTH-1:0]   tree_outp,
   output logic                   out_valid,
   output logic [DATAWIDTH-1:0]   out_sum,
   input  logic                   out_ready,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                 state;
   logic [DATAWIDTH-1:0]   acc;
   logic [LEN_WIDTH-1:0]   remaining;
   logic [DATAWIDTH-1:0]   lane [4];
   logic                   accept;
   logic                   last_beat;

   // A beat is taken only in ACCUM. Abort blocks the beat in the same cycle.
   assign in_ready    = (state == ACCUM) && !abort;
   assign accept      = in_valid && in_ready;
   assign last_beat   = (remaining <= LEN_WIDTH'(4));
   assign tree_ex_inp = acc;

   // Zero the lanes at or past the remaining element count so a short tail beat adds nothing.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane[k] = '0;
         if ((state == ACCUM) && (remaining > LEN_WIDTH'(k)))
            lane[k] = in_data[k*DATAWIDTH +: DATAWIDTH];
      end
   end

   assign tree_inp0 = lane[0];
   assign tree_inp1 = lane[1];
   assign tree_inp2 = lane[2];
   assign tree_inp3 = lane[3];

   // Control FSM. The tree result is written back into acc on every accepted beat.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         busy      <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= vec_len;
                  acc       <= '0;
                  busy      <= 1'b1;
                  if (vec_len == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_sum   <= '0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= tree_outp;
                  if (last_beat) begin
                     remaining <= '0;
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_sum   <= tree_outp;
                  end else begin
                     remaining <= remaining - LEN_WIDTH'(4);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mode4_accum_ctrl.sv
// Bench for mode4_accum_ctrl. It stands in for the external fp16 adder tree with a real-valued model.
// Each vector's expected sum is queued at start and popped when the sum is handed off.
// Covers lane masking, gaps in in_valid, out_ready backpressure, zero length, abort, reset, and an ignored restart.
module tb_mode4_accum_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  vec_len = '0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready;
   logic [15:0] tree_inp0, tree_inp1, tree_inp2, tree_inp3, tree_ex_inp;
   logic [15:0] tree_outp;
   logic        out_valid;
   logic [15:0] out_sum;
   logic        out_ready = 1'b0;
   logic        busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] sb_q[$];
   int          lat;

   localparam logic [63:0] ONES = {4{16'h3C00}};
   localparam logic [63:0] TWOS = {4{16'h4000}};
   localparam logic [63:0] GARB = {16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h3C00};

   always #5 clk = ~clk;

   mode4_accum_ctrl #(.DATAWIDTH(16), .LEN_WIDTH(10)) dut (
      .clk(clk), .resetn(resetn), .start(start), .vec_len(vec_len), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .tree_inp0(tree_inp0), .tree_inp1(tree_inp1), .tree_inp2(tree_inp2), .tree_inp3(tree_inp3),
      .tree_ex_inp(tree_ex_inp), .tree_outp(tree_outp),
      .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready), .busy(busy)
   );

   // fp16 (non-negative) to real
   function automatic real f2r(input logic [15:0] h);
      real v;
      int  e;
      e = int'(h[14:10]);
      if (e == 31) return 1.0e9;
      if (e == 0) begin
         v = real'(int'(h[9:0]));
         e = -24;
      end else begin
         v = 1.0 + real'(int'(h[9:0])) / 1024.0;
         e = e - 15;
      end
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return v;
   endfunction

   // non-negative real to fp16, round to nearest, saturating to +inf
   function automatic logic [15:0] r2f(input real r);
      real m;
      int  e;
      int  frac;
      logic [4:0] ef;
      logic [9:0] ff;
      if (r <= 0.0) return 16'h0000;
      if (r >= 65520.0) return 16'h7C00;
      m = r;
      e = 15;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
      if (m < 1.0) begin
         frac = $rtoi(m * 1024.0 + 0.5);
         e = 0;
      end else begin
         frac = $rtoi((m - 1.0) * 1024.0 + 0.5);
         if (frac == 1024) begin frac = 0; e++; end
      end
      ef = e[4:0];
      ff = frac[9:0];
      return {1'b0, ef, ff};
   endfunction

   // Behavioral stand-in for the combinational adder tree
   always_comb begin
      tree_outp = r2f(f2r(tree_inp0) + f2r(tree_inp1) + f2r(tree_inp2) + f2r(tree_inp3) + f2r(tree_ex_inp));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop the expected sum on every handshake
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("sb_unexpected_out", 32'(out_sum), 32'hFFFF_FFFF);
         else chk("out_sum", 32'(out_sum), 32'(sb_q.pop_front()));
      end
   end

   // Runs one vector. The first beat carries d0 and later beats carry d1, with gap idle cycles between beats.
   task automatic run_vec(input logic [9:0] len, input logic [63:0] d0, input logic [63:0] d1,
                          input int gap, input logic [15:0] part, input logic restart,
                          input logic [15:0] exp_sum, output int lat_o);
      int nb, sent, idle;
      bit acc_now, rdy_seen;
      nb = (int'(len) + 3) / 4;
      sent = 0; idle = 0; lat_o = 0; rdy_seen = 0;
      sb_q.push_back(exp_sum);
      start = 1'b1;
      vec_len = len;
      while (!out_valid && lat_o < 100) begin
         in_valid = (sent < nb) && (idle == 0);
         in_data = (sent == 0) ? d0 : d1;
         if (restart && lat_o == 2) begin start = 1'b1; vec_len = 10'd4; end
         #1;
         if (in_ready) rdy_seen = 1;
         acc_now = in_valid && in_ready;
         if (gap > 0 && idle > 0 && sent == 1) chk("gap_acc_hold", 32'(tree_ex_inp), 32'(part));
         step();
         lat_o++;
         start = 1'b0;
         if (acc_now) begin sent++; idle = gap; end
         else if (idle > 0) idle--;
      end
      in_valid = 1'b0;
      if (lat_o >= 100) chk("out_valid_timeout", 32'(out_valid), 32'd1);
      if (len == 0) chk("zero_len_in_ready", 32'(rdy_seen), 32'd0);
   endtask

   // Holds out_ready low for hold cycles, then completes the handshake
   task automatic finish_out(input int hold, input logic [15:0] exp_sum);
      chk("done_busy", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_sum", 32'(out_sum), 32'(exp_sum));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tree_inp0", 32'(tree_inp0), 32'd0);
      chk("rst_ex_inp", 32'(tree_ex_inp), 32'd0);
      #20 resetn = 1'b1;
      step();

      // Eight elements in two back-to-back beats of 1.0
      run_vec(10'd8, ONES, ONES, 0, 16'h0, 1'b0, 16'h4800, lat);
      chk("lat_len8", 32'(lat), 32'd3);
      finish_out(0, 16'h4800);

      // Five elements: lanes 1-3 of the tail beat are masked
      run_vec(10'd5, ONES, GARB, 0, 16'h0, 1'b0, 16'h4500, lat);
      chk("lat_len5", 32'(lat), 32'd3);
      finish_out(0, 16'h4500);

      // Gapped input, then the consumer stalls the result
      run_vec(10'd8, TWOS, TWOS, 3, 16'h4800, 1'b0, 16'h4C00, lat);
      chk("lat_gapped", 32'(lat), 32'd6);
      finish_out(4, 16'h4C00);

      // Zero length
      run_vec(10'd0, ONES, ONES, 0, 16'h0, 1'b0, 16'h0000, lat);
      chk("lat_zero", 32'(lat), 32'd1);
      finish_out(0, 16'h0000);

      // Abort after the first beat, then a clean vector
      start = 1'b1; vec_len = 10'd12;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = ONES;
      step();
      chk("abort_pre_acc", 32'(tree_ex_inp), 32'h4400);
      abort = 1'b1;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      step();
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_acc", 32'(tree_ex_inp), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      run_vec(10'd4, ONES, ONES, 0, 16'h0, 1'b0, 16'h4400, lat);
      chk("lat_after_abort", 32'(lat), 32'd2);
      finish_out(0, 16'h4400);

      // Same scenario, but reset is pulsed instead of abort
      start = 1'b1; vec_len = 10'd12;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = ONES;
      step();
      resetn = 1'b0;
      #2;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_acc", 32'(tree_ex_inp), 32'd0);
      chk("rst_mid_inp0", 32'(tree_inp0), 32'd0);
      resetn = 1'b1;
      in_valid = 1'b0;
      step();
      run_vec(10'd4, ONES, ONES, 0, 16'h0, 1'b0, 16'h4400, lat);
      chk("lat_after_rst", 32'(lat), 32'd2);
      finish_out(0, 16'h4400);

      // A start pulsed during ACCUM with a different length is ignored
      run_vec(10'd8, ONES, ONES, 0, 16'h0, 1'b1, 16'h4800, lat);
      chk("lat_restart_ignored", 32'(lat), 32'd3);
      finish_out(0, 16'h4800);

      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mode4_accum_ctrl.md
Name: mode4_accum_ctrl

Overview:
Sequencer for the mode-4 FP adder tree (4 lanes plus an external-add operand, combinational, `DATAWIDTH` wide). It accumulates a vector of exponent values, 4 elements per beat, into the softmax denominator. It drives the tree lanes from an input stream and feeds back a running-sum register through the tree's external operand. Sits between the exp stage and the reciprocal/divide stage.

Parameters:
DATAWIDTH, 16, FP word width (fp16: 10-bit mantissa, 5-bit exponent).
LEN_WIDTH, 10, width of the vector-length field, in elements.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  1-cycle pulse; begins a new vector; honoured only in IDLE.
vec_len  in  LEN_WIDTH  element count, sampled when start is accepted.
abort  in  1  synchronous abort; returns to IDLE from any state.
in_valid  in  1  input beat valid.
in_data  in  4*DATAWIDTH  lanes; lane k = bits [k*DATAWIDTH +: DATAWIDTH].
in_ready  out  1  beat accepted when in_valid && in_ready.
tree_inp0..tree_inp3  out  DATAWIDTH each  to adder tree inp0..inp3.
tree_ex_inp  out  DATAWIDTH  to adder tree ex_inp; equals acc.
tree_outp  in  DATAWIDTH  adder tree result.
out_valid  out  1  sum available.
out_sum  out  DATAWIDTH  final sum.
out_ready  in  1  consumer accepts the sum.
busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (resetn=0, async): state=IDLE, acc=0, remaining=0, in_ready=0, out_valid=0, out_sum=0, busy=0. Tree outputs are therefore 0.
- FP zero is all-zero bits (+0.0).
- States:
  - IDLE: on start, latch remaining=vec_len and clear acc to 0. If vec_len==0, go to DONE (out_sum=0). Otherwise go to ACCUM.
  - ACCUM: in_ready=1 combinationally, and only in this state.
    - On each accepted beat: acc<=tree_outp, and remaining<=remaining-4 (saturating at 0).
    - If remaining<=4 at acceptance, the beat is last: go to DONE, with out_sum<=tree_outp in the same edge.
    - With no in_valid, hold acc and remaining.
  - DONE: out_valid=1 and out_sum stable. When out_ready is high at an edge, go to IDLE and drop out_valid.
- Lane masking: tree_inpk = in_data lane k if k < remaining (or remaining>=4), else 0.
  - Applied in every ACCUM cycle regardless of in_valid.
  - All tree_inp are forced to 0 outside ACCUM.
- Single-cycle datapath: tree is combinational, so acc updates on the edge that accepts the beat. Throughput is one beat per cycle.
- Latency: out_valid rises the cycle after the last beat is accepted. Minimum start-to-out_valid = ceil(vec_len/4)+1 cycles.
- start is ignored while busy; vec_len is not resampled.
- abort:
  - Has priority over start, acceptance and out_ready.
  - Next state IDLE; acc, remaining, out_valid cleared.
  - A beat presented in the abort cycle is not accepted (in_ready=0 when abort=1).
- start and out_ready in the same DONE cycle: DONE→IDLE only; start is ignored.
- busy=1 in ACCUM and DONE.
- Reset asserted mid-vector: immediate return to reset values; no partial sum emitted.

Test Plan:
- vec_len=8, two back-to-back beats, all lanes 0x3C00 (1.0) -> out_valid 3 cycles after start, out_sum=0x4800 (8.0), busy falls after out_ready.
- vec_len=5, beat1 all 0x3C00, beat2 lanes 0x3C00 plus garbage 0x7BFF in lanes 1-3 -> lanes 1-3 masked to 0, out_sum=0x4500 (5.0).
- vec_len=8, in_valid gapped with 3 idle cycles between beats, lanes 0x4000 (2.0) -> acc held during gaps, out_sum=0x4C00 (16.0). Hold out_ready=0 for 4 cycles -> out_sum stays stable with out_valid=1.
- vec_len=0 start -> DONE next cycle, out_sum=0x0000, in_ready never asserted.
- vec_len=12: abort after the first beat -> IDLE, acc=0. Then a new start with vec_len=4, lanes 0x3C00 -> out_sum=0x4400 (4.0) with no residue. Repeat with resetn pulsed low instead of abort -> same result.
- start pulsed during ACCUM with a different vec_len -> ignored; the original length completes.
